cocofdc_bus_arbiter: RTL and testbench
======================================

// Module: cocofdc_bus_arbiter
// PURPOSE
//  Clocked, parametrised arbiter for the shared EEPROM bus in the CoCo FDC CPLD.
//  N power-gated hosts (host 0 = CoCo, host 1 = AVR, more optional) request single accesses.
//  One winner is granted; the block sequences EEPROM OE/WE strobes with counted setup, strobe and hold.
//  Read data returns to the winner with a one-cycle ack.
// PARAMETERS
//  NUM_HOSTS   2   number of requesting hosts (1..8)
//  ADDR_W      15  address width
//  DATA_W      8   data width
//  SETUP_CYC   1   cycles addr/data stable before strobe (>=1)
//  STROBE_CYC  4   cycles OE_n/WE_n held low (>=1)
//  HOLD_CYC    1   cycles addr/data held after strobe release (>=1)
// PORTS
//  clk       in   1                  system clock; all logic on rising edge
//  reset     in   1                  synchronous, active-high reset
//  h_power   in   NUM_HOSTS          1 = host powered; an unpowered host's req is ignored
//  h_req     in   NUM_HOSTS          level request; held until ack
//  h_rw      in   NUM_HOSTS          1 = read, 0 = write
//  h_addr    in   NUM_HOSTS*ADDR_W   packed per-host address; host i at [i*ADDR_W +: ADDR_W]
//  h_wdata   in   NUM_HOSTS*DATA_W   packed per-host write data
//  h_grant   out  NUM_HOSTS          one-hot; current owner, high from SETUP through HOLD
//  h_ack     out  NUM_HOSTS          one-cycle pulse to the owner at access completion
//  h_rdata   out  DATA_W             read data; valid in the ack cycle, held until the next read
//  e_addr    out  ADDR_W             EEPROM address
//  e_wdata   out  DATA_W             EEPROM write data
//  e_wdata_oe out 1                  1 = drive e_wdata onto the EEPROM bus (write owner only)
//  e_rdata   in   DATA_W             EEPROM read data
//  e_oe_n    out  1                  EEPROM output enable, active low
//  e_we_n    out  1                  EEPROM write enable, active low
// BEHAVIOUR
//  Reset: state=IDLE, h_grant=0, h_ack=0, h_rdata=0, e_addr=0, e_wdata=0, e_wdata_oe=0, e_oe_n=1, e_we_n=1.
//  Eligible request: h_req[i] & h_power[i].
//  IDLE: if any request is eligible, latch winner, rw, addr and wdata; go to SETUP next cycle.
//    Latency: req-to-SETUP is 1 cycle.
//  SETUP: hold for SETUP_CYC cycles.
//    e_addr and e_wdata are driven; e_wdata_oe = ~rw; both strobes are high.
//  STROBE: hold for STROBE_CYC cycles; e_oe_n = ~rw, e_we_n = rw.
//    On the last STROBE cycle, a read registers e_rdata into h_rdata.
//  HOLD: hold for HOLD_CYC cycles; strobes high; addr, data and e_wdata_oe unchanged.
//    On the last HOLD cycle, pulse h_ack[owner]. Next state is IDLE.
//    Total access = 1 + SETUP_CYC + STROBE_CYC + HOLD_CYC cycles from req.
//  One counter of width $clog2(max cycle param + 1) serves all phases; it is reloaded on every state entry.
//  Latched addr/wdata/rw do not change mid-access, even if the host changes its inputs.
//  Owner drops h_req or loses h_power mid-access: the access completes anyway (EEPROM write integrity).
//    The ack is still pulsed.
//  The owner must deassert h_req in the cycle after ack.
//    A request still high in the IDLE cycle after ack is a new request.
//  Strobes are never both low. e_we_n never falls unless e_wdata_oe has been high for >= SETUP_CYC cycles.
//  Reset mid-access: all strobes return high in the next cycle and no ack is issued.
//  Simultaneous requests: resolved by the priority rule below. Losers wait; none is ever dropped.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN undefined: fixed priority; lowest index wins (CoCo first).
//  ARB_ROUND_ROBIN_EN defined: round-robin.
//    Search starts at (last_owner+1) mod NUM_HOSTS. last_owner resets to NUM_HOSTS-1, so host 0 wins first.
//    No eligible host waits more than NUM_HOSTS-1 accesses.
// STRUCTURE
//  Package cocofdc_pkg holds:
//    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD} arb_state_t;
//    constants HOST_COCO=0, HOST_AVR=1.
//  Sub-module cocofdc_arb_pick: combinational winner select.
//    Inputs: eligible vector, last_owner. Outputs: one-hot winner, any.
//    Holds the fixed-priority and round-robin variants under the macro.
//  Top: FSM, phase counter, datapath latches, strobe registers (all outputs registered).
// TESTING
//  1. Host1 read addr 0x1234, e_rdata=0xA5, defaults.
//     -> e_oe_n low 4 cycles, e_we_n high throughout.
//     -> h_ack[1] in cycle 7 after req; h_rdata=0xA5.
//  2. Host0 write 0x0042<-0x5A.
//     -> e_wdata_oe high from SETUP; e_we_n low exactly 4 cycles; e_oe_n=1.
//     -> h_ack[0] one cycle; no rdata change.
//  3. h_req=2'b11 in the same cycle.
//     -> fixed priority: host0 served, then host1.
//     -> ARB_ROUND_ROBIN_EN: after host0, host1 wins the next contest even if host0 re-requests.
//  4. h_req[1]=1 with h_power[1]=0 -> no grant, no strobe, for 20 cycles.
//     Raise h_power[1] -> served.
//  5. Reset asserted during STROBE of a write.
//     -> e_we_n=1, e_wdata_oe=0, h_grant=0 the next cycle; no ack.
//  6. Owner drops req during SETUP -> access completes, ack pulses.
//     Assertion checks throughout: never (~e_oe_n & ~e_we_n), h_grant one-hot-or-zero.

Source files
------------

// File: rtl/cocofdc_pkg.sv
// Shared types and constants for the CoCo FDC EEPROM bus arbiter.
package cocofdc_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD} arb_state_t;

   localparam int unsigned HOST_COCO = 0;
   localparam int unsigned HOST_AVR  = 1;

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/cocofdc_arb_pick.sv
// Combinational winner select for the EEPROM bus arbiter.
// Build option: ARB_ROUND_ROBIN_EN selects round-robin; otherwise lowest index wins.
module cocofdc_arb_pick #(
   parameter int unsigned NUM_HOSTS = 2,
   parameter int unsigned LO_W      = 1
) (
   input  logic [NUM_HOSTS-1:0] eligible,
   input  logic [LO_W-1:0]      last_owner,
   output logic [NUM_HOSTS-1:0] winner,
   output logic                 any
);

   assign any = |eligible;

`ifdef ARB_ROUND_ROBIN_EN
   logic [31:0] idx;
   logic        found;

   // Search starts just after the previous owner and wraps around.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = '0;
      for (int unsigned off = 1; off <= NUM_HOSTS; off++) begin
         idx = (32'(last_owner) + off) % NUM_HOSTS;
         if (!found && eligible[idx[LO_W-1:0]]) begin
            winner[idx[LO_W-1:0]] = 1'b1;
            found                 = 1'b1;
         end
      end
   end
`else
   logic unused_last_owner;
   assign unused_last_owner = ^last_owner;

   always_comb begin
      winner = '0;
      for (int i = NUM_HOSTS - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            winner    = '0;
            winner[i] = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/cocofdc_bus_arbiter.sv
// Shared EEPROM bus arbiter for the CoCo FDC: grants one host and sequences OE/WE strobes.
// Build option: ARB_ROUND_ROBIN_EN selects round-robin arbitration (default fixed priority).
import cocofdc_pkg::*;

module cocofdc_bus_arbiter #(
   parameter int unsigned NUM_HOSTS  = 2,
   parameter int unsigned ADDR_W     = 15,
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned SETUP_CYC  = 1,
   parameter int unsigned STROBE_CYC = 4,
   parameter int unsigned HOLD_CYC   = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_HOSTS-1:0]         h_power,
   input  logic [NUM_HOSTS-1:0]         h_req,
   input  logic [NUM_HOSTS-1:0]         h_rw,
   input  logic [NUM_HOSTS*ADDR_W-1:0]  h_addr,
   input  logic [NUM_HOSTS*DATA_W-1:0]  h_wdata,
   output logic [NUM_HOSTS-1:0]         h_grant,
   output logic [NUM_HOSTS-1:0]         h_ack,
   output logic [DATA_W-1:0]            h_rdata,
   output logic [ADDR_W-1:0]            e_addr,
   output logic [DATA_W-1:0]            e_wdata,
   output logic                         e_wdata_oe,
   input  logic [DATA_W-1:0]            e_rdata,
   output logic                         e_oe_n,
   output logic                         e_we_n
);

   localparam int unsigned LO_W    = (NUM_HOSTS > 1) ? $clog2(NUM_HOSTS) : 1;
   localparam int unsigned MAX_CYC = max3(SETUP_CYC, STROBE_CYC, HOLD_CYC);
   localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

   arb_state_t           state;
   logic [CNT_W-1:0]     cnt;
   logic [LO_W-1:0]      last_owner;
   logic                 rw;

   logic [NUM_HOSTS-1:0] eligible;
   logic [NUM_HOSTS-1:0] winner;
   logic                 any;
   logic [LO_W-1:0]      win_idx;
   logic                 sel_rw;
   logic [ADDR_W-1:0]    sel_addr;
   logic [DATA_W-1:0]    sel_wdata;

   assign eligible = h_req & h_power;

   cocofdc_arb_pick #(
      .NUM_HOSTS (NUM_HOSTS),
      .LO_W      (LO_W)
   ) u_pick (
      .eligible   (eligible),
      .last_owner (last_owner),
      .winner     (winner),
      .any        (any)
   );

   always_comb begin
      win_idx   = '0;
      sel_rw    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_HOSTS; i++) begin
         if (winner[i]) begin
            win_idx   = LO_W'(i);
            sel_rw    = h_rw[i];
            sel_addr  = h_addr[i*ADDR_W +: ADDR_W];
            sel_wdata = h_wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   // Owner's req/power are not consulted after the grant so an access always runs to completion.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         last_owner <= LO_W'(NUM_HOSTS - 1);
         rw         <= 1'b0;
         h_grant    <= '0;
         h_ack      <= '0;
         h_rdata    <= '0;
         e_addr     <= '0;
         e_wdata    <= '0;
         e_wdata_oe <= 1'b0;
         e_oe_n     <= 1'b1;
         e_we_n     <= 1'b1;
      end else begin
         h_ack <= '0;
         unique case (state)
            ST_IDLE: begin
               if (any) begin
                  state      <= ST_SETUP;
                  cnt        <= CNT_W'(SETUP_CYC - 1);
                  h_grant    <= winner;
                  last_owner <= win_idx;
                  rw         <= sel_rw;
                  e_addr     <= sel_addr;
                  e_wdata    <= sel_wdata;
                  e_wdata_oe <= ~sel_rw;
               end
            end
            ST_SETUP: begin
               if (cnt == '0) begin
                  state  <= ST_STROBE;
                  cnt    <= CNT_W'(STROBE_CYC - 1);
                  e_oe_n <= ~rw;
                  e_we_n <= rw;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            ST_STROBE: begin
               if (cnt == '0) begin
                  state  <= ST_HOLD;
                  cnt    <= CNT_W'(HOLD_CYC - 1);
                  e_oe_n <= 1'b1;
                  e_we_n <= 1'b1;
                  if (rw) h_rdata <= e_rdata;
                  if (HOLD_CYC == 1) h_ack <= h_grant;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            ST_HOLD: begin
               if (cnt == '0) begin
                  state      <= ST_IDLE;
                  h_grant    <= '0;
                  e_wdata_oe <= 1'b0;
               end else begin
                  cnt <= cnt - CNT_W'(1);
                  // Ack is registered, so raise it on entry to the final hold cycle.
                  if (cnt == CNT_W'(1)) h_ack <= h_grant;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cocofdc_bus_arbiter.sv
// Self-checking bench for cocofdc_bus_arbiter: vector table, corner sequences, random traffic.
module tb_cocofdc_bus_arbiter;

   localparam int N   = 2;
   localparam int AW  = 15;
   localparam int DW  = 8;
   localparam int S   = 1;
   localparam int ST  = 4;
   localparam int H   = 1;
   localparam int TOT = S + ST + H;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [N-1:0]    h_power = '0;
   logic [N-1:0]    h_req = '0;
   logic [N-1:0]    h_rw = '0;
   logic [N*AW-1:0] h_addr = '0;
   logic [N*DW-1:0] h_wdata = '0;
   logic [DW-1:0]   e_rdata = '0;
   logic [N-1:0]    h_grant;
   logic [N-1:0]    h_ack;
   logic [DW-1:0]   h_rdata;
   logic [AW-1:0]   e_addr;
   logic [DW-1:0]   e_wdata;
   logic            e_wdata_oe;
   logic            e_oe_n;
   logic            e_we_n;

   cocofdc_bus_arbiter #(
      .NUM_HOSTS  (N),
      .ADDR_W     (AW),
      .DATA_W     (DW),
      .SETUP_CYC  (S),
      .STROBE_CYC (ST),
      .HOLD_CYC   (H)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .h_power    (h_power),
      .h_req      (h_req),
      .h_rw       (h_rw),
      .h_addr     (h_addr),
      .h_wdata    (h_wdata),
      .h_grant    (h_grant),
      .h_ack      (h_ack),
      .h_rdata    (h_rdata),
      .e_addr     (e_addr),
      .e_wdata    (e_wdata),
      .e_wdata_oe (e_wdata_oe),
      .e_rdata    (e_rdata),
      .e_oe_n     (e_oe_n),
      .e_we_n     (e_we_n)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: an access is a timeline of t = 1..TOT cycles after the winner is chosen.
   bit            m_busy = 1'b0;
   int            m_t = 0;
   int            m_owner = 0;
   int            m_last = N - 1;
   bit            m_rw = 1'b0;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_wdata = '0;
   logic [DW-1:0] m_rdata = '0;

   function automatic int pick(input logic [N-1:0] el);
`ifdef ARB_ROUND_ROBIN_EN
      for (int k = 1; k <= N; k++) begin
         int j;
         j = (m_last + k) % N;
         if (el[j]) return j;
      end
`else
      for (int j = 0; j < N; j++) if (el[j]) return j;
`endif
      return -1;
   endfunction

   task automatic model_step();
      int w;
      if (reset) begin
         m_busy = 1'b0; m_t = 0; m_last = N - 1;
         m_addr = '0; m_wdata = '0; m_rdata = '0;
      end else if (!m_busy) begin
         w = pick(h_req & h_power);
         if (w >= 0) begin
            m_busy  = 1'b1; m_t = 1; m_owner = w; m_last = w;
            m_rw    = h_rw[w];
            m_addr  = h_addr[w*AW +: AW];
            m_wdata = h_wdata[w*DW +: DW];
         end
      end else begin
         if (m_t == S + ST && m_rw) m_rdata = e_rdata;
         if (m_t == TOT) m_busy = 1'b0;
         else m_t++;
      end
   endtask

   task automatic check_outputs();
      bit strobe;
      strobe = m_busy && (m_t > S) && (m_t <= S + ST);
      chk("grant",    h_grant,    m_busy ? (1 << m_owner) : 0);
      chk("ack",      h_ack,      (m_busy && m_t == TOT) ? (1 << m_owner) : 0);
      chk("oe_n",     e_oe_n,     !(strobe && m_rw));
      chk("we_n",     e_we_n,     !(strobe && !m_rw));
      chk("wdata_oe", e_wdata_oe, m_busy && !m_rw);
      chk("e_addr",   e_addr,     m_addr);
      chk("e_wdata",  e_wdata,    m_wdata);
      chk("h_rdata",  h_rdata,    m_rdata);
      chk("strobes_exclusive", (!e_oe_n && !e_we_n), 0);
      chk("grant_onehot0", $onehot0(h_grant), 1);
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic set_host(input int i, input bit rw, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
      h_rw[i] = rw;
      h_addr[i*AW +: AW] = a;
      h_wdata[i*DW +: DW] = d;
      h_req[i] = 1'b1;
   endtask

   typedef struct {
      int            host;
      bit            rw;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] erd;
      int            exp_ack;    // request cycle counts as cycle 1
      int            exp_oe_lo;
      int            exp_we_lo;
      int            exp_doe;    // cycles with e_wdata_oe high
      logic [DW-1:0] exp_rdata;
   } vec_t;

   vec_t vecs[5];

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc, oe_lo, we_lo, doe, n, raise_at, busy_seen, ack_seen, acks;
      int order[3];
      bit done, reraised;

      vecs[0] = '{1, 1'b1, 15'h1234, 8'h00, 8'hA5, 7, 4, 0, 0, 8'hA5};
      vecs[1] = '{0, 1'b0, 15'h0042, 8'h5A, 8'h3C, 7, 0, 4, 6, 8'hA5};
      vecs[2] = '{0, 1'b1, 15'h7FFF, 8'h00, 8'hFF, 7, 4, 0, 0, 8'hFF};
      vecs[3] = '{1, 1'b0, 15'h0000, 8'h00, 8'h81, 7, 0, 4, 6, 8'hFF};
      vecs[4] = '{1, 1'b1, 15'h0001, 8'hEE, 8'h00, 7, 4, 0, 0, 8'h00};

      reset = 1'b1;
      tick();
      tick();
      chk("rst_grant", h_grant, 0);
      chk("rst_oe_n", e_oe_n, 1);
      chk("rst_we_n", e_we_n, 1);
      chk("rst_rdata", h_rdata, 0);
      reset = 1'b0;
      h_power = '1;
      tick();

      // Table-driven single accesses
      foreach (vecs[v]) begin
         set_host(vecs[v].host, vecs[v].rw, vecs[v].addr, vecs[v].wdata);
         e_rdata = vecs[v].erd;
         cyc = 1; oe_lo = 0; we_lo = 0; doe = 0; done = 1'b0;
         for (int k = 0; k < 30 && !done; k++) begin
            tick();
            cyc++;
            if (!e_oe_n) oe_lo++;
            if (!e_we_n) we_lo++;
            if (e_wdata_oe) doe++;
            if (h_ack[vecs[v].host]) begin
               done = 1'b1;
               h_req[vecs[v].host] = 1'b0;
            end
         end
         chk($sformatf("vec%0d_ack_cycle", v), done ? cyc : 0, vecs[v].exp_ack);
         chk($sformatf("vec%0d_oe_low", v), oe_lo, vecs[v].exp_oe_lo);
         chk($sformatf("vec%0d_we_low", v), we_lo, vecs[v].exp_we_lo);
         chk($sformatf("vec%0d_wdata_oe", v), doe, vecs[v].exp_doe);
         chk($sformatf("vec%0d_rdata", v), h_rdata, vecs[v].exp_rdata);
         chk($sformatf("vec%0d_addr", v), e_addr, vecs[v].addr);
         chk($sformatf("vec%0d_wdata", v), e_wdata, vecs[v].wdata);
         tick();
      end

      // Simultaneous requests; host 0 re-requests once right after its first ack
      reset = 1'b1;
      tick();
      reset = 1'b0;
      set_host(0, 1'b0, 15'h0100, 8'h11);
      set_host(1, 1'b1, 15'h0200, 8'h22);
      order = '{-1, -1, -1};
      n = 0; raise_at = -1; reraised = 1'b0; cyc = 0;
      for (int k = 0; k < 60 && n < 3; k++) begin
         if (cyc == raise_at) h_req[0] = 1'b1;
         tick();
         cyc++;
         for (int i = 0; i < N; i++) begin
            if (h_ack[i]) begin
               if (n < 3) order[n] = i;
               n++;
               h_req[i] = 1'b0;
               if (i == 0 && !reraised) begin
                  reraised = 1'b1;
                  raise_at = cyc + 1;
               end
            end
         end
      end
      chk("contest_acks", n, 3);
      chk("contest_first", order[0], 0);
`ifdef ARB_ROUND_ROBIN_EN
      chk("contest_second", order[1], 1);
      chk("contest_third", order[2], 0);
`else
      chk("contest_second", order[1], 0);
      chk("contest_third", order[2], 1);
`endif
      h_req = '0;
      tick();

      // Unpowered host is ignored until power comes up
      h_power = 2'b01;
      set_host(1, 1'b1, 15'h0333, 8'h00);
      e_rdata = 8'h77;
      busy_seen = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (h_grant != 0 || !e_oe_n || !e_we_n) busy_seen++;
      end
      chk("unpowered_activity", busy_seen, 0);
      h_power = '1;
      done = 1'b0;
      for (int k = 0; k < 20 && !done; k++) begin
         tick();
         if (h_ack[1]) begin done = 1'b1; h_req[1] = 1'b0; end
      end
      chk("powered_served", done, 1);
      chk("powered_rdata", h_rdata, 8'h77);
      tick();

      // Reset during the strobe phase of a write
      set_host(0, 1'b0, 15'h0444, 8'hC3);
      for (int k = 0; k < 20 && e_we_n; k++) tick();
      chk("rst_reached_strobe", e_we_n, 0);
      tick();
      reset = 1'b1;
      tick();
      chk("rst_mid_we_n", e_we_n, 1);
      chk("rst_mid_wdata_oe", e_wdata_oe, 0);
      chk("rst_mid_grant", h_grant, 0);
      chk("rst_mid_ack", h_ack, 0);
      reset = 1'b0;
      h_req[0] = 1'b0;
      ack_seen = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (h_ack != 0) ack_seen++;
      end
      chk("rst_no_ack", ack_seen, 0);

      // Owner drops its request during SETUP
      set_host(1, 1'b1, 15'h0555, 8'h00);
      e_rdata = 8'h9E;
      tick();
      chk("drop_setup_grant", h_grant, 2'b10);
      h_req[1] = 1'b0;
      done = 1'b0;
      for (int k = 0; k < 20 && !done; k++) begin
         tick();
         if (h_ack[1]) done = 1'b1;
      end
      chk("drop_setup_ack", done, 1);
      chk("drop_setup_rdata", h_rdata, 8'h9E);
      tick();

      // Random traffic: inputs churn every cycle, model checks each cycle
      acks = 0;
      for (int k = 0; k < 2500; k++) begin
         for (int i = 0; i < N; i++) begin
            if (h_ack[i]) h_req[i] = 1'b0;
            else if (!h_req[i]) h_req[i] = ($urandom_range(0, 2) == 0);
            else if ($urandom_range(0, 15) == 0) h_req[i] = 1'b0;
            h_power[i] = ($urandom_range(0, 7) != 0);
            h_rw[i] = 1'($urandom);
            h_addr[i*AW +: AW] = AW'($urandom);
            h_wdata[i*DW +: DW] = DW'($urandom);
         end
         e_rdata = DW'($urandom);
         reset = ($urandom_range(0, 299) == 0);
         tick();
         if (h_ack != 0) acks++;
      end
      chk("random_acks_seen", (acks > 50), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
